// File: rtl/clusterv_sram_bridge_pkg.sv
// Shared types and default sizing for the Wishbone-to-SRAM bridge.
// The RD_REG state exists only when CLUSTERV_SRAM_BRIDGE_RDATA_REG_EN is defined.
package clusterv_sram_bridge_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int STATE_WIDTH        = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
`ifdef CLUSTERV_SRAM_BRIDGE_RDATA_REG_EN
        ST_RD_REG  = 3'd2,
`endif
        ST_ACK     = 3'd3,
        ST_ERR     = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/clusterv_sram_wb_bridge.sv
// Wishbone classic target to single-port byte-enable SRAM bridge.
// Define CLUSTERV_SRAM_BRIDGE_RDATA_REG_EN to add a read-data pipeline stage (read ack at +3).
module clusterv_sram_wb_bridge
    import clusterv_sram_bridge_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int          DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [31:0]               t_adr,
    input  logic [DATA_WIDTH-1:0]     t_dat_w,
    input  logic [DATA_WIDTH/8-1:0]   t_sel,
    input  logic                      t_we,
    input  logic                      t_cyc,
    input  logic                      t_stb,
    output logic [DATA_WIDTH-1:0]     t_dat_r,
    output logic                      t_ack,
    output logic                      t_err,

    output logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      i_read_en,
    output logic                      i_write_en,
    output logic [DATA_WIDTH/8-1:0]   i_byte_en,
    output logic [DATA_WIDTH-1:0]     i_write_data,
    input  logic [DATA_WIDTH-1:0]     i_read_data,

    output logic [STATE_WIDTH-1:0]    dbg_state
);

    localparam int BE_W = DATA_WIDTH / 8;

    // Handshake: a request (t_cyc & t_stb) is taken only in IDLE; the initiator
    // must hold it until t_ack or t_err, each a single-cycle registered pulse.
    // Dropping t_cyc while a read is in flight abandons it without a response.

    bridge_state_t state;

    logic accept;
    logic in_window;
    logic issue_wr;
    logic issue_rd;
    logic unused_adr_bits;

    assign unused_adr_bits = ^t_adr[1:0];

    assign accept    = (state == ST_IDLE) && t_cyc && t_stb && !reset;
    assign in_window = (t_adr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign issue_wr  = accept && in_window && t_we;
    assign issue_rd  = accept && in_window && !t_we;

    // SRAM strobes are combinational in the accept cycle; all fields idle at zero.
    always_comb begin
        i_addr       = '0;
        i_read_en    = 1'b0;
        i_write_en   = 1'b0;
        i_byte_en    = '0;
        i_write_data = '0;
        if (issue_wr || issue_rd) begin
            i_addr = t_adr[ADDR_WIDTH+1:2];
        end
        if (issue_rd) begin
            i_read_en = 1'b1;
        end
        if (issue_wr) begin
            i_write_en   = 1'b1;
            i_byte_en    = t_sel;
            i_write_data = t_dat_w;
        end
    end

`ifdef CLUSTERV_SRAM_BRIDGE_RDATA_REG_EN
    logic [DATA_WIDTH-1:0] rd_pipe;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            t_ack   <= 1'b0;
            t_err   <= 1'b0;
            t_dat_r <= '0;
`ifdef CLUSTERV_SRAM_BRIDGE_RDATA_REG_EN
            rd_pipe <= '0;
`endif
        end else begin
            t_ack <= 1'b0;
            t_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!in_window) begin
                            state <= ST_ERR;
                            t_err <= 1'b1;
                        end else if (t_we) begin
                            state <= ST_ACK;
                            t_ack <= 1'b1;
                        end else begin
                            state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (!t_cyc) begin
                        state <= ST_IDLE;
                    end else begin
`ifdef CLUSTERV_SRAM_BRIDGE_RDATA_REG_EN
                        rd_pipe <= i_read_data;
                        state   <= ST_RD_REG;
`else
                        t_dat_r <= i_read_data;
                        state   <= ST_ACK;
                        t_ack   <= 1'b1;
`endif
                    end
                end
`ifdef CLUSTERV_SRAM_BRIDGE_RDATA_REG_EN
                ST_RD_REG: begin
                    if (!t_cyc) begin
                        state <= ST_IDLE;
                    end else begin
                        t_dat_r <= rd_pipe;
                        state   <= ST_ACK;
                        t_ack   <= 1'b1;
                    end
                end
`endif
                ST_ACK:  state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
